cmd_responder: RTL



---
 rtl/cmd_responder_pkg.sv | 37 +++
 rtl/cmd_responder_if.sv | 48 ++++
 rtl/cmd_responder_crc7.sv | 31 +++
 rtl/cmd_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cmd_responder_pkg.sv
// Shared definitions for the card-side CMD line responder: FSM encoding, frame geometry
// and the CRC7 step used by both the receive and transmit paths.
package cmd_responder_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRcvCmd,
        StRcvCrc,
        StRcvEnd,
        StDiscard,
        StWaitApp,
        StNcrWait,
        StSendResp,
        StSendCrc,
        StSendEnd
    } state_e;

    localparam int unsigned FrameLenShort = 48;
    localparam int unsigned FrameLenLong  = 136;
    localparam int unsigned CrcSpanShort  = 40;
    localparam int unsigned CrcSpanLong   = 120;
    localparam int unsigned CrcBits       = 7;

    localparam int unsigned NcrMin = 2;
    localparam int unsigned NcrMax = 64;

    // x^7 + x^3 + 1, leading term implicit
    localparam logic [CrcBits-1:0] Crc7Poly = 7'h09;

    function automatic logic [CrcBits-1:0] crc7_step(input logic [CrcBits-1:0] crc,
                                                     input logic din);
        logic fb;
        fb = din ^ crc[CrcBits-1];
        return {crc[CrcBits-2:0], 1'b0} ^ (fb ? Crc7Poly : '0);
    endfunction

endpackage

// File: rtl/cmd_responder_if.sv
// CMD line and application handshake bundle; slave = responder, master = host/app side.
interface cmd_responder_if;
    import cmd_responder_pkg::*;

    logic                   icmd_sd;
    logic                   ocmd_sd;
    logic                   ocmd_oe;
    logic                   ocmd_valid;
    logic [5:0]             ocmd_index;
    logic [31:0]            ocmd_arg;
    logic                   ocrc_err;
    logic                   iresp_valid;
    logic                   iresp_skip;
    logic                   iresp_long;
    logic [CrcSpanLong-1:0] iresp_content;
    logic                   odone;

    modport slave (
        input  icmd_sd,
        input  iresp_valid,
        input  iresp_skip,
        input  iresp_long,
        input  iresp_content,
        output ocmd_sd,
        output ocmd_oe,
        output ocmd_valid,
        output ocmd_index,
        output ocmd_arg,
        output ocrc_err,
        output odone
    );

    modport master (
        output icmd_sd,
        output iresp_valid,
        output iresp_skip,
        output iresp_long,
        output iresp_content,
        input  ocmd_sd,
        input  ocmd_oe,
        input  ocmd_valid,
        input  ocmd_index,
        input  ocmd_arg,
        input  ocrc_err,
        input  odone
    );

endinterface

// File: rtl/cmd_responder_crc7.sv
// Serial CRC7 generator. In unload mode the register shifts out MSB first instead of
// accumulating, so the same flops serve for compare (receive) and emit (transmit).
module cmd_responder_crc7
    import cmd_responder_pkg::*;
(
    input  logic iclk,
    input  logic iclr,
    input  logic ien,
    input  logic iunload,
    input  logic idata,
    output logic ocrc_msb
);

    logic [CrcBits-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (iclr) begin
            crc_d = '0;
        end else if (ien) begin
            crc_d = iunload ? {crc_q[CrcBits-2:0], 1'b0} : crc7_step(crc_q, idata);
        end
    end

    always_ff @(posedge iclk) begin
        crc_q <= crc_d;
    end

    assign ocrc_msb = crc_q[CrcBits-1];

endmodule

// File: rtl/cmd_responder.sv
// Card-side SD CMD line responder: receives host command frames, checks CRC7 and framing,
// then returns a 48-bit or 136-bit response after the NCR gap.
module cmd_responder
    import cmd_responder_pkg::*;
#(
    parameter int unsigned NCR = 2  // legal 2..64; out-of-range values are clamped
) (
    input  logic           iclk,
    input  logic           irst,
    cmd_responder_if.slave bus
);

    localparam int unsigned NcrEff = (NCR < NcrMin) ? NcrMin : ((NCR > NcrMax) ? NcrMax : NCR);

    // NCR_WAIT lasts NCR-1 cycles: the output register adds the last released cycle
    localparam logic [7:0] NcrLast     = 8'(NcrEff - 2);
    localparam logic [7:0] RxBodyLast  = 8'(CrcSpanShort - 2);
    localparam logic [7:0] DiscardLast = 8'(FrameLenShort - 3);
    localparam logic [7:0] CrcLast     = 8'(CrcBits - 1);
    localparam logic [7:0] TxShortLast = 8'(CrcSpanShort - 1);
    localparam logic [7:0] TxLongLast  = 8'(FrameLenLong - CrcBits - 2);
    localparam logic [7:0] R2CrcFirst  = 8'(FrameLenLong - CrcBits - 1 - CrcSpanLong);

    state_e       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [37:0]  rx_q, rx_d;
    logic         crc_bad_q, crc_bad_d;
    logic [127:0] tx_q, tx_d;
    logic         long_q, long_d;

    logic         ocmd_sd_q, ocmd_sd_d;
    logic         ocmd_oe_q, ocmd_oe_d;
    logic         ocmd_valid_q, ocmd_valid_d;
    logic         ocrc_err_q, ocrc_err_d;
    logic         odone_q, odone_d;
    logic [5:0]   ocmd_index_q, ocmd_index_d;
    logic [31:0]  ocmd_arg_q, ocmd_arg_d;

    logic         crc_clr, crc_en, crc_unload, crc_din, crc_msb;
    logic         rx_good;
    logic [7:0]   tx_last;

    assign rx_good = ~crc_bad_q & bus.icmd_sd;
    assign tx_last = long_q ? TxLongLast : TxShortLast;

    cmd_responder_crc7 u_crc7 (
        .iclk     (iclk),
        .iclr     (crc_clr),
        .ien      (crc_en),
        .iunload  (crc_unload),
        .idata    (crc_din),
        .ocrc_msb (crc_msb)
    );

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!bus.icmd_sd) state_d = StRcvCmd;
            StRcvCmd: begin
                if (cnt_q == 8'd0 && !bus.icmd_sd) state_d = StDiscard;
                else if (cnt_q == RxBodyLast)      state_d = StRcvCrc;
            end
            StRcvCrc:   if (cnt_q == CrcLast) state_d = StRcvEnd;
            StRcvEnd:   state_d = rx_good ? StWaitApp : StIdle;
            StDiscard:  if (cnt_q == DiscardLast) state_d = StIdle;
            StWaitApp: begin
                if (bus.iresp_valid)     state_d = StNcrWait;
                else if (bus.iresp_skip) state_d = StIdle;
            end
            StNcrWait:  if (cnt_q == NcrLast) state_d = StSendResp;
            StSendResp: if (cnt_q == tx_last) state_d = StSendCrc;
            StSendCrc:  if (cnt_q == CrcLast) state_d = StSendEnd;
            StSendEnd:  state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Line outputs are registered from the current state, so the line trails the FSM by one.
    always_comb begin
        ocmd_oe_d    = 1'b0;
        ocmd_sd_d    = 1'b1;
        ocmd_valid_d = 1'b0;
        ocrc_err_d   = 1'b0;
        ocmd_index_d = ocmd_index_q;
        ocmd_arg_d   = ocmd_arg_q;
        unique case (state_q)
            StRcvEnd: begin
                if (rx_good) begin
                    ocmd_valid_d = 1'b1;
                    ocmd_index_d = rx_q[37:32];
                    ocmd_arg_d   = rx_q[31:0];
                end else begin
                    ocrc_err_d = 1'b1;
                end
            end
            StSendResp: begin
                ocmd_oe_d = 1'b1;
                ocmd_sd_d = tx_q[127];
            end
            StSendCrc: begin
                ocmd_oe_d = 1'b1;
                ocmd_sd_d = crc_msb;
            end
            StSendEnd: begin
                ocmd_oe_d = 1'b1;
                ocmd_sd_d = 1'b1;
            end
            default: ;
        endcase
        odone_d = ocmd_oe_q & ~ocmd_oe_d;
    end

    always_comb begin
        cnt_d     = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
        rx_d      = rx_q;
        crc_bad_d = crc_bad_q;
        tx_d      = tx_q;
        long_d    = long_q;
        unique case (state_q)
            StRcvCmd: begin
                rx_d      = {rx_q[36:0], bus.icmd_sd};
                crc_bad_d = 1'b0;
            end
            StRcvCrc: if (bus.icmd_sd != crc_msb) crc_bad_d = 1'b1;
            StWaitApp: begin
                if (bus.iresp_valid) begin
                    long_d = bus.iresp_long;
                    // frame is left-aligned: start/transmission bits then the body
                    tx_d   = bus.iresp_long ? {2'b00, 6'h3f, bus.iresp_content}
                                            : {2'b00, bus.iresp_content[119:82], 88'd0};
                end
            end
            StSendResp: tx_d = {tx_q[126:0], 1'b0};
            default: ;
        endcase
    end

    always_comb begin
        crc_clr    = irst;
        crc_en     = 1'b0;
        crc_unload = 1'b0;
        crc_din    = bus.icmd_sd;
        unique case (state_q)
            StIdle, StWaitApp, StNcrWait: crc_clr = 1'b1;
            StRcvCmd: crc_en = 1'b1;
            StRcvCrc: begin
                crc_en     = 1'b1;
                crc_unload = 1'b1;
            end
            StSendResp: begin
                // R2 CRC covers only the 120 content bits
                crc_en  = ~long_q | (cnt_q >= R2CrcFirst);
                crc_din = tx_q[127];
            end
            StSendCrc: begin
                crc_en     = 1'b1;
                crc_unload = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            cnt_q        <= '0;
            rx_q         <= '0;
            crc_bad_q    <= 1'b0;
            tx_q         <= '0;
            long_q       <= 1'b0;
            ocmd_sd_q    <= 1'b1;
            ocmd_oe_q    <= 1'b0;
            ocmd_valid_q <= 1'b0;
            ocrc_err_q   <= 1'b0;
            odone_q      <= 1'b0;
            ocmd_index_q <= '0;
            ocmd_arg_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            rx_q         <= rx_d;
            crc_bad_q    <= crc_bad_d;
            tx_q         <= tx_d;
            long_q       <= long_d;
            ocmd_sd_q    <= ocmd_sd_d;
            ocmd_oe_q    <= ocmd_oe_d;
            ocmd_valid_q <= ocmd_valid_d;
            ocrc_err_q   <= ocrc_err_d;
            odone_q      <= odone_d;
            ocmd_index_q <= ocmd_index_d;
            ocmd_arg_q   <= ocmd_arg_d;
        end
    end

    assign bus.ocmd_sd    = ocmd_sd_q;
    assign bus.ocmd_oe    = ocmd_oe_q;
    assign bus.ocmd_valid = ocmd_valid_q;
    assign bus.ocrc_err   = ocrc_err_q;
    assign bus.odone      = odone_q;
    assign bus.ocmd_index = ocmd_index_q;
    assign bus.ocmd_arg   = ocmd_arg_q;

endmodule
